// File: rtl/pc_redirect_unit.sv
// PC sequencer for the RV32IC core: sequential advance by 2/4 bytes, redirect with a fixed flush window.
// Optional feature macro: MISALIGN_TRAP_EN (odd redirect targets vector to TRAP_VEC and pulse misalign_trap).
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        is_compressed,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_link,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign_trap
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        flush_q, flush_d;
    logic        trap_q, trap_d;

    logic        redirect;
    logic        misaligned;
    logic [31:0] target_pc;
    logic        unused_cfg;

    assign redirect = branch_taken | jump;
    assign pc_link  = pc_q + (is_compressed ? 32'd2 : 32'd4);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = redirect_target[0];
    assign target_pc  = misaligned ? {TRAP_VEC[31:1], 1'b0} : {redirect_target[31:1], 1'b0};
    assign unused_cfg = 1'b0;
`else
    assign misaligned = 1'b0;
    assign target_pc  = {redirect_target[31:1], 1'b0};
    // Target bit 0 and the trap vector only matter when the trap feature is built in.
    assign unused_cfg = ^{redirect_target[0], TRAP_VEC};
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = flush_q;
        trap_d        = 1'b0;

        case (state_q)
            RUN: begin
                if (!fetch_valid_q) begin
                    // First cycle out of reset: start fetching at RESET_PC.
                    fetch_valid_d = 1'b1;
                end else if (redirect) begin
                    pc_d          = target_pc;
                    state_d       = FLUSH;
                    cnt_d         = CNT_LOAD;
                    flush_d       = 1'b1;
                    fetch_valid_d = 1'b0;
                    trap_d        = misaligned;
                end else if (!stall) begin
                    pc_d = {pc_link[31:1], 1'b0};
                end
            end
            FLUSH: begin
                // Inputs here belong to squashed instructions and are ignored.
                if (cnt_q == 3'd0) begin
                    state_d       = RUN;
                    flush_d       = 1'b0;
                    fetch_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            pc_q          <= {RESET_PC[31:1], 1'b0};
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            trap_q        <= trap_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_valid   = fetch_valid_q;
    assign flush         = flush_q;
    assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with an expected-state scoreboard.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        is_compressed;
    logic        branch_taken;
    logic        jump;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] pc_link;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_trap;

    pc_redirect_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .is_compressed   (is_compressed),
        .branch_taken    (branch_taken),
        .jump            (jump),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_link         (pc_link),
        .fetch_valid     (fetch_valid),
        .flush           (flush),
        .misalign_trap   (misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        tr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_pc = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] epc,
                             input logic efv, input logic efl, input logic etr);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(efv));
        chk({tag, ".flush"}, 32'(flush), 32'(efl));
        chk({tag, ".trap"}, 32'(misalign_trap), 32'(etr));
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare after the edge.
    task automatic step(input string tag, input logic st, input logic c, input logic bt,
                        input logic j, input logic [31:0] tgt, input logic [31:0] epc,
                        input logic efv, input logic efl, input logic etr);
        exp_t e;
        logic [31:0] exp_link;
        stall           = st;
        is_compressed   = c;
        branch_taken    = bt;
        jump            = j;
        redirect_target = tgt;
        e.tag = tag; e.pc = epc; e.fv = efv; e.fl = efl; e.tr = etr;
        sb.push_back(e);
        exp_link = cur_pc + (c ? 32'd2 : 32'd4);
        #1;
        chk({tag, ".link"}, pc_link, exp_link);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_state(e.tag, e.pc, e.fv, e.fl, e.tr);
        cur_pc = e.pc;
    endtask

    logic exp_trap;
    logic [31:0] exp_mis_pc;

    initial begin
`ifdef MISALIGN_TRAP_EN
        exp_trap   = 1'b1;
        exp_mis_pc = 32'h0000_0100;
`else
        exp_trap   = 1'b0;
        exp_mis_pc = 32'h0000_0200;
`endif
        rst_n = 1'b0; stall = 1'b0; is_compressed = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; redirect_target = 32'h0;
        #2;
        chk_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step("start", 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0);

        // Sequential advance with mixed instruction lengths
        step("seq0", 0, 0, 0, 0, 32'h0, 32'h4, 1, 0, 0);
        step("seq1", 0, 1, 0, 0, 32'h0, 32'h6, 1, 0, 0);
        step("seq2", 0, 1, 0, 0, 32'h0, 32'h8, 1, 0, 0);
        step("seq3", 0, 0, 0, 0, 32'h0, 32'hC, 1, 0, 0);

        // Taken branch and two-cycle flush window
        step("br",   0, 0, 1, 0, 32'h200, 32'h200, 0, 1, 0);
        step("brf1", 0, 0, 0, 0, 32'h0,   32'h200, 0, 1, 0);
        step("brv",  0, 0, 0, 0, 32'h0,   32'h200, 1, 0, 0);
        step("brn",  0, 0, 0, 0, 32'h0,   32'h204, 1, 0, 0);

        // Jump followed by a dropped branch during flush; stall ignored in flush
        step("jmp",  0, 0, 0, 1, 32'h80,  32'h80, 0, 1, 0);
        step("drop", 0, 0, 1, 0, 32'h400, 32'h80, 0, 1, 0);
        step("jmpv", 1, 0, 0, 0, 32'h0,   32'h80, 1, 0, 0);
        step("jmpn", 0, 1, 0, 0, 32'h0,   32'h82, 1, 0, 0);

        // Redirect beats stall; stall alone holds
        step("stbr",  1, 0, 1, 0, 32'h300, 32'h300, 0, 1, 0);
        step("stbf",  0, 0, 0, 0, 32'h0,   32'h300, 0, 1, 0);
        step("stbv",  0, 0, 0, 0, 32'h0,   32'h300, 1, 0, 0);
        step("hold0", 1, 0, 0, 0, 32'h0,   32'h300, 1, 0, 0);
        step("hold1", 1, 1, 0, 0, 32'h0,   32'h300, 1, 0, 0);
        step("hold2", 1, 0, 0, 0, 32'h0,   32'h300, 1, 0, 0);
        step("unst",  0, 0, 0, 0, 32'h0,   32'h304, 1, 0, 0);

        // Wrap-around at the top of the address space
        step("wj4",  0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 0);
        step("wf4",  0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 1, 0);
        step("wv4",  0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0);
        step("wrap4",0, 0, 0, 0, 32'h0,         32'h0,         1, 0, 0);
        step("wj2",  0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 1, 0);
        step("wf2",  0, 0, 0, 0, 32'h0,         32'hFFFF_FFFE, 0, 1, 0);
        step("wv2",  0, 0, 0, 0, 32'h0,         32'hFFFF_FFFE, 1, 0, 0);
        step("wrap2",0, 1, 0, 0, 32'h0,         32'h0,         1, 0, 0);

        // Odd redirect target
        step("mis",  0, 0, 1, 0, 32'h201, exp_mis_pc, 0, 1, exp_trap);
        step("misf", 0, 0, 0, 0, 32'h0,   exp_mis_pc, 0, 1, 0);
        step("misv", 0, 0, 0, 0, 32'h0,   exp_mis_pc, 1, 0, 0);

        // Asynchronous reset in the middle of a flush
        step("rj",   0, 0, 0, 1, 32'h500, 32'h500, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("rstmid", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_state("rsthold", 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        cur_pc = 32'h0;
        step("rstart", 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
        step("rseq",   0, 0, 0, 0, 32'h0, 32'h4, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
